// File: rtl/pipeline_exec_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_exec_ctrl
//
// Execution controller for the 5-stage MIPS pipeline. A small FSM sequences
// the pipeline through idle, continuous run, single-step, halted and clear
// modes under command from the debug unit. It also detects a HALT instruction
// reaching WB. Its freeze is merged with the hazard-detection stall and flush
// lines, so the PC and the pipeline registers see one coherent set of
// controls.
//
// Optional feature (compile-time macro PIPE_CYCLE_COUNT_EN):
//   defined   - a saturating executed-cycle counter drives o_cycle_count
//   undefined - no counter is built and o_cycle_count is tied to zero
//
// Parameters:
//   CNT_W             width of the executed-cycle counter
//
// Ports:
//   i_clk             system clock
//   i_reset           synchronous active-high reset
//   i_run_cmd         pulse: start continuous execution
//   i_step_cmd        pulse: execute exactly one clock
//   i_pause_cmd       pulse: stop continuous execution
//   i_restart_cmd     pulse: clear the pipeline and return to idle
//   i_halt_WB         HALT instruction is in WB this cycle
//   i_stall_pc_HD     PC stall from hazard detection
//   i_stall_if_id_HD  IF/ID stall from hazard detection
//   i_flush_id_ex_HD  ID/EX flush from hazard detection
//   o_pipe_enable     global write enable for PC, pipeline regs, register file
//   o_stall_pc        merged PC stall
//   o_stall_if_id     merged IF/ID stall
//   o_flush_id_ex     merged ID/EX flush
//   o_pipe_reset      one-cycle synchronous clear for PC and pipeline regs
//   o_state           current FSM state encoding
//   o_halted          high while halted
//   o_cycle_count     executed-cycle count
// ---------------------------------------------------------------------------
module pipeline_exec_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run_cmd,
    input  logic             i_step_cmd,
    input  logic             i_pause_cmd,
    input  logic             i_restart_cmd,
    input  logic             i_halt_WB,
    input  logic             i_stall_pc_HD,
    input  logic             i_stall_if_id_HD,
    input  logic             i_flush_id_ex_HD,
    output logic             o_pipe_enable,
    output logic             o_stall_pc,
    output logic             o_stall_if_id,
    output logic             o_flush_id_ex,
    output logic             o_pipe_reset,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_CLEAR  = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Commands that do not apply in the current state are
    // simply dropped. i_halt_WB is only looked at in RUN/STEP: while frozen,
    // the WB register still holds the HALT and would re-trigger.
    always_comb begin
        state_next = state_reg;
        if (i_restart_cmd) begin
            state_next = ST_CLEAR;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (i_run_cmd) begin
                        state_next = ST_RUN;
                    end else if (i_step_cmd) begin
                        state_next = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (i_halt_WB) begin
                        state_next = ST_HALTED;
                    end else if (i_pause_cmd) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (i_halt_WB) begin
                        state_next = ST_HALTED;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_HALTED: state_next = ST_HALTED;
                ST_CLEAR:  state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs come from the registered state plus the HD lines. A flush is
    // suppressed while frozen, so a held bubble or instruction survives.
    assign o_pipe_enable = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign o_stall_pc    = i_stall_pc_HD    || !o_pipe_enable;
    assign o_stall_if_id = i_stall_if_id_HD || !o_pipe_enable;
    assign o_flush_id_ex = i_flush_id_ex_HD &&  o_pipe_enable;
    assign o_pipe_reset  = (state_reg == ST_CLEAR);
    assign o_halted      = (state_reg == ST_HALTED);
    assign o_state       = state_reg;

`ifdef PIPE_CYCLE_COUNT_EN
    logic [CNT_W-1:0] count_reg;

    // Counts enabled edges and saturates at all-ones. It holds in HALTED
    // because the enable is low there.
    always_ff @(posedge i_clk) begin
        if (i_reset || (state_reg == ST_CLEAR)) begin
            count_reg <= '0;
        end else if (o_pipe_enable && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign o_cycle_count = count_reg;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_exec_ctrl
//
// Self-checking bench for pipeline_exec_ctrl. A behavioural model tracks the
// execution mode and the executed-cycle count. Directed sequences cover
// step, run/pause, halt vs pause, HD merging, restart, run+step priority,
// counter saturation (CNT_W=4) and reset mid-run. A randomized phase
// follows. Inputs change on the falling edge. Outputs are compared 1 ns
// later, and the model advances on the rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_exec_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run_cmd = 1'b0, step_cmd = 1'b0, pause_cmd = 1'b0, restart_cmd = 1'b0;
    logic             halt_wb = 1'b0, stall_pc_hd = 1'b0, stall_if_id_hd = 1'b0, flush_id_ex_hd = 1'b0;
    logic             pipe_enable, stall_pc, stall_if_id, flush_id_ex, pipe_reset, halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_count;

    pipeline_exec_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_run_cmd        (run_cmd),
        .i_step_cmd       (step_cmd),
        .i_pause_cmd      (pause_cmd),
        .i_restart_cmd    (restart_cmd),
        .i_halt_WB        (halt_wb),
        .i_stall_pc_HD    (stall_pc_hd),
        .i_stall_if_id_HD (stall_if_id_hd),
        .i_flush_id_ex_HD (flush_id_ex_hd),
        .o_pipe_enable    (pipe_enable),
        .o_stall_pc       (stall_pc),
        .o_stall_if_id    (stall_if_id),
        .o_flush_id_ex    (flush_id_ex),
        .o_pipe_reset     (pipe_reset),
        .o_state          (state),
        .o_halted         (halted),
        .o_cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    int err_count = 0;
    int chk_count = 0;
    int cyc_num   = 0;

    // Model: mode names the controller's current activity, 0..4 numbered as
    // the published state encoding (idle, run, step, halted, clear).
    int model_mode  = 0;
    int model_count = 0;
    int count_max   = (1 << CNT_W) - 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc_num);
        end
    endtask

    // One clock of stimulus: apply inputs, check outputs, advance the model.
    task automatic cyc(input logic rst, input logic run, input logic step,
                       input logic pause, input logic restart, input logic halt,
                       input logic spc, input logic sif, input logic fl);
        bit executing;
        int exp_cnt;
        @(negedge clk);
        reset = rst; run_cmd = run; step_cmd = step; pause_cmd = pause;
        restart_cmd = restart; halt_wb = halt;
        stall_pc_hd = spc; stall_if_id_hd = sif; flush_id_ex_hd = fl;
        #1;
        executing = (model_mode == 1) || (model_mode == 2);
`ifdef PIPE_CYCLE_COUNT_EN
        exp_cnt = model_count;
`else
        exp_cnt = 0;
`endif
        check_val("state",       32'(state),       32'(model_mode));
        check_val("pipe_enable", 32'(pipe_enable), 32'(executing));
        check_val("stall_pc",    32'(stall_pc),    32'(spc || !executing));
        check_val("stall_if_id", 32'(stall_if_id), 32'(sif || !executing));
        check_val("flush_id_ex", 32'(flush_id_ex), 32'(fl && executing));
        check_val("pipe_reset",  32'(pipe_reset),  32'(model_mode == 4));
        check_val("halted",      32'(halted),      32'(model_mode == 3));
        check_val("cycle_count", 32'(cycle_count), 32'(exp_cnt));
        $display("cyc %0d rst=%0b run=%0b step=%0b pause=%0b rstrt=%0b halt=%0b hd=%0b%0b%0b -> state=%0d en=%0b cnt=%0d",
                 cyc_num, rst, run, step, pause, restart, halt, spc, sif, fl,
                 state, pipe_enable, cycle_count);
        @(posedge clk);
        cyc_num++;
        // Counter: cleared by reset or while clearing, else counts executed
        // clocks up to the all-ones ceiling.
        if (rst || model_mode == 4) model_count = 0;
        else if (executing && model_count < count_max) model_count = model_count + 1;
        // Mode transitions.
        if (rst)                             model_mode = 0;
        else if (restart)                    model_mode = 4;
        else if (model_mode == 4)            model_mode = 0;
        else if (model_mode == 0)            model_mode = run ? 1 : (step ? 2 : 0);
        else if (model_mode == 1)            model_mode = halt ? 3 : (pause ? 0 : 1);
        else if (model_mode == 2)            model_mode = halt ? 3 : 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Initial reset: outputs are undefined until the first edge.
        repeat (2) @(posedge clk);
        model_mode = 0; model_count = 0;

        // Reset values with reset still held, then single step in cycle 2.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Run, ten cycles, pause.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Halt and pause together while running; later commands ignored.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(1);

        // Restart from halted, then run+step together.
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        // HD merging while running, then while paused.
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);

        // Saturation: run long enough to pass 15.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(20);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(1);

        // Step that sees HALT in WB, then restart.
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Reset mid-run beats restart.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(2);

        // Randomized phase.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

endmodule

// File: doc/pipeline_exec_ctrl.md
# pipeline_exec_ctrl

Execution controller for the 5-stage MIPS pipeline. Sequences the pipeline in run, single-step and halted modes under command from the debug unit, and detects the HALT instruction reaching WB. Merges its freeze with the hazard-detection stall/flush lines so the PC and pipeline registers see a single coherent set of controls. Optionally counts executed clock cycles for the debug readout.

## Interface
Parameters:
- CNT_W, 32, width of the executed-cycle counter

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  reset; synchronous, active-high
- i_run_cmd  in  1  one-cycle pulse: start continuous execution
- i_step_cmd  in  1  one-cycle pulse: execute exactly one clock
- i_pause_cmd  in  1  one-cycle pulse: stop continuous execution
- i_restart_cmd  in  1  one-cycle pulse: clear pipeline and return to IDLE
- i_halt_WB  in  1  HALT instruction is in WB this cycle
- i_stall_pc_HD  in  1  stall PC, from hazard detection
- i_stall_if_id_HD  in  1  stall IF/ID, from hazard detection
- i_flush_id_ex_HD  in  1  flush ID/EX, from hazard detection
- o_pipe_enable  out  1  global write enable for PC, pipeline registers and register file
- o_stall_pc  out  1  merged PC stall
- o_stall_if_id  out  1  merged IF/ID stall
- o_flush_id_ex  out  1  merged ID/EX flush
- o_pipe_reset  out  1  one-cycle synchronous clear for PC and pipeline registers
- o_state  out  3  current FSM state encoding
- o_halted  out  1  high in HALTED
- o_cycle_count  out  CNT_W  executed-cycle count

## Operation
- State encoding: IDLE=0, RUN=1, STEP=2, HALTED=3, CLEAR=4.
- Transitions, evaluated in priority order:
  - i_restart_cmd in any state → CLEAR.
  - CLEAR → IDLE unconditionally.
  - IDLE: i_run_cmd → RUN; else i_step_cmd → STEP. If both are asserted, RUN wins.
  - RUN: i_halt_WB → HALTED; else i_pause_cmd → IDLE. Halt has priority over pause.
  - STEP: i_halt_WB → HALTED; else → IDLE. STEP always lasts exactly one cycle.
  - HALTED: holds. run, step and pause commands are ignored.
- Commands arriving in states where they do not apply are dropped, not queued.
- Output equations:
  - o_pipe_enable = (state==RUN) | (state==STEP).
  - o_stall_pc = i_stall_pc_HD | ~o_pipe_enable.
  - o_stall_if_id = i_stall_if_id_HD | ~o_pipe_enable.
  - o_flush_id_ex = i_flush_id_ex_HD & o_pipe_enable. No flush while frozen, so a held bubble or instruction is not destroyed.
  - o_pipe_reset = (state==CLEAR).
  - o_halted = (state==HALTED).
- i_halt_WB is ignored while o_pipe_enable=0. The WB register is frozen and would otherwise re-trigger.
- The cycle that presents HALT in WB is itself enabled, so the HALT commits. The freeze takes effect from the next cycle.

## Timing
- Reset values: state=IDLE, o_pipe_enable=0, o_stall_pc=1, o_stall_if_id=1, o_flush_id_ex=0, o_pipe_reset=0, o_halted=0, o_cycle_count=0.
- State register updates on the rising edge of i_clk. All outputs are derived from the registered state, plus the combinational HD inputs.
- Command latency: a command pulse in cycle N changes o_pipe_enable in cycle N+1.
- i_reset asserted mid-RUN: the next edge gives IDLE and the pipeline freezes. i_reset beats i_restart_cmd.
- Counter:
  - Increments on each edge where o_pipe_enable=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared by i_reset and in CLEAR.
  - Holds in HALTED.

## Configuration
- PIPE_CYCLE_COUNT_EN defined: o_cycle_count is implemented as described above.
- PIPE_CYCLE_COUNT_EN undefined: no counter register is built and o_cycle_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then i_step_cmd pulse in cycle 2 → o_pipe_enable high only in cycle 3; state 0→2→0; o_cycle_count=1.
- Reset, i_run_cmd, 10 cycles, i_pause_cmd → o_pipe_enable high for exactly 11 cycles; o_cycle_count=11; state back to IDLE.
- RUN with i_halt_WB=1 and i_pause_cmd=1 in the same cycle → next state HALTED (3), o_halted=1, o_pipe_enable=0; later run/step pulses leave state at 3.
- RUN with i_stall_pc_HD=1, i_flush_id_ex_HD=1 → o_stall_pc=1, o_flush_id_ex=1. After pause, same HD inputs → o_stall_pc=1, o_flush_id_ex=0.
- HALTED, i_restart_cmd → one cycle with o_pipe_reset=1 and state=4, then IDLE with o_cycle_count=0. Also i_run_cmd and i_step_cmd together in IDLE → RUN.
- With CNT_W=4, run for 20 cycles → o_cycle_count saturates at 15. Build without PIPE_CYCLE_COUNT_EN → o_cycle_count stays 0 throughout.
